instr_fetch: RTL and testbench

Instruction fetch stage that produces the instruction stream consumed by the control unit / decoder. It requests words from instruction memory over a req/ack handshake and holds the fetched word in an instruction register. It presents opcode/funct/full instruction to decode over a valid/ready handshake. It applies branch/jump redirects and stops permanently on a halt request (SYSCALL).

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_perf_ctr.sv | 42 ++++
 rtl/instr_fetch.sv | 152 +++++++++++++++
 tb/tb_instr_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction width and the
// opcode/funct encodings the decoder also uses.
package cpu_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OPC_W  = 6;

    localparam logic [OPC_W-1:0] RTYPE   = 6'b000000;
    localparam logic [OPC_W-1:0] SYSCALL = 6'b001100;
    localparam logic [OPC_W-1:0] ADD     = 6'b100000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Major opcode field of an instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W-1:0] word);
        return word[31:26];
    endfunction

    // Minor funct field of an instruction word.
    function automatic logic [OPC_W-1:0] funct_of(input logic [INST_W-1:0] word);
        return word[5:0];
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: accepted instructions and stall cycles.
// Both wrap at 2^32 and freeze once fetch has halted.
module fetch_perf_ctr
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        hs_i,
    input  logic        stall_i,
    input  logic        halted_i,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
);

    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Next-count logic; counters hold while halted.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (!halted_i) begin
            if (hs_i)    fetch_count_d = fetch_count_q + 32'd1;
            if (stall_i) stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count_o = fetch_count_q;
    assign stall_count_o = stall_count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack fetch from instruction memory into an
// instruction register, valid/ready delivery to decode, branch/jump
// redirect and permanent halt. Instruction width is cpu_pkg::INST_W.
// Optional macro FETCH_PERF_EN adds fetch_count/stall_count outputs.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_b,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic              misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              mem_req_q, mem_req_d;
    logic              inst_valid_q, inst_valid_d;
    logic              halted_q, halted_d;
    logic              misalign_q, misalign_d;
    logic              hs_c;

    assign hs_c = inst_valid_q & inst_ready;

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        mem_req_d    = mem_req_q;
        inst_valid_d = inst_valid_q;
        halted_d     = halted_q;
        misalign_d   = misalign_q;
        unique case (state_q)
            FETCH: begin
                // An ack only counts while a request is actually outstanding.
                if (mem_req_q && mem_ack) begin
                    inst_d       = mem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = HOLD;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            HOLD: begin
                mem_req_d = 1'b0;
                if (hs_c) begin
                    inst_valid_d = 1'b0;
                    if (halt_req) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        // Request the next word straight away so the only
                        // bubble is the cycle inst_valid is low.
                        state_d   = FETCH;
                        mem_req_d = 1'b1;
                        if (redirect_valid) begin
                            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
                            if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
                        end else begin
                            pc_d = pc_q + ADDR_W'(4);
                        end
                    end
                end
            end
            HALTED: begin
                mem_req_d    = 1'b0;
                inst_valid_d = 1'b0;
                halted_d     = 1'b1;
            end
            default: begin
                state_d   = FETCH;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
            misalign_q   <= misalign_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = pc_q;
    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign opcode       = opcode_of(inst_q);
    assign funct        = funct_of(inst_q);
    assign inst_pc      = inst_pc_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
    // Stall: request waiting on memory, or instruction waiting on decode.
    logic stall_c;
    assign stall_c = (mem_req_q & ~mem_ack) | (inst_valid_q & ~inst_ready);

    fetch_perf_ctr u_perf (
        .clk           (clk),
        .rst_b         (rst_b),
        .hs_i          (hs_c),
        .stall_i       (stall_c),
        .halted_i      (halted_q),
        .fetch_count_o (fetch_count),
        .stall_count_o (stall_count)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by a
// randomized run checked against a transaction-level PC/memory model.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, mem_req, mem_ack, inst_valid, inst_ready;
    logic        redirect_valid, halt_req, halted, misalign_err;
    logic [31:0] mem_addr, mem_rdata, inst, inst_pc, redirect_pc;
    logic [5:0]  opcode, funct;

    logic        b_rst_b, b_mem_req, b_mem_ack, b_inst_valid, b_inst_ready;
    logic        b_halted, b_misalign_err;
    logic [31:0] b_mem_addr, b_mem_rdata, b_inst, b_inst_pc;
    logic [5:0]  b_opcode, b_funct;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count, b_fetch_count, b_stall_count;
`endif

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_b(rst_b), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .opcode(opcode), .funct(funct),
        .inst_pc(inst_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted),
        .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_top (
        .clk(clk), .rst_b(b_rst_b), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
        .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata), .inst_valid(b_inst_valid),
        .inst_ready(b_inst_ready), .inst(b_inst), .opcode(b_opcode),
        .funct(b_funct), .inst_pc(b_inst_pc), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .halt_req(1'b0), .halted(b_halted),
        .misalign_err(b_misalign_err)
`ifdef FETCH_PERF_EN
        , .fetch_count(b_fetch_count), .stall_count(b_stall_count)
`endif
    );

    // Deterministic memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, counting a handshake that the coming edge will take.
    task automatic tick();
        if (inst_valid && inst_ready) hs_cnt++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        exp_mis;
        int          hs0, rnd_hs;
`ifdef FETCH_PERF_EN
        logic [31:0] stall0;
`endif
        rst_b = 1'b0; mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        b_rst_b = 1'b0; b_mem_ack = 1'b0; b_mem_rdata = '0; b_inst_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_valid", 64'(inst_valid), 64'(0));
        check("rst_halted", 64'(halted), 64'(0));
        check("rst_misalign", 64'(misalign_err), 64'(0));
        check("rst_inst", 64'(inst), 64'(0));
        check("rst_inst_pc", 64'(inst_pc), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));

        // 1: zero-wait fetch of an ADD
        rst_b = 1'b1;
        tick();
        check("t1_req", 64'(mem_req), 64'(1));
        check("t1_addr", 64'(mem_addr), 64'(0));
        mem_ack = 1'b1; mem_rdata = 32'h0000_0020;
        tick();
        check("t1_valid", 64'(inst_valid), 64'(1));
        check("t1_opcode", 64'(opcode), 64'(RTYPE));
        check("t1_funct", 64'(funct), 64'(ADD));
        check("t1_inst_pc", 64'(inst_pc), 64'(0));
        check("t1_req_drop", 64'(mem_req), 64'(0));
        mem_ack = 1'b0; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t1_next_addr", 64'(mem_addr), 64'(4));
        check("t1_next_req", 64'(mem_req), 64'(1));
        check("t1_bubble", 64'(inst_valid), 64'(0));

        // 2: wait states on memory and on decode
        mem_ack = 1'b1; mem_rdata = 32'h0000_0020;
        tick();
        mem_ack = 1'b0; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
        stall0 = stall_count;
`endif
        hs0 = hs_cnt;
        for (int i = 0; i < 3; i++) begin
            check("t2_req_wait", 64'(mem_req), 64'(1));
            check("t2_addr_wait", 64'(mem_addr), 64'(32'h8));
            tick();
        end
        check("t2_addr_before_ack", 64'(mem_addr), 64'(32'h8));
        mem_ack = 1'b1; mem_rdata = 32'h0123_4567;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t2_valid_stall", 64'(inst_valid), 64'(1));
            check("t2_inst_stall", 64'(inst), 64'(32'h0123_4567));
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t2_one_hs", 64'(hs_cnt - hs0), 64'(1));
        check("t2_next_addr", 64'(mem_addr), 64'(32'hC));
`ifdef FETCH_PERF_EN
        check("t2_stall_count", 64'(stall_count - stall0), 64'(5));
`endif

        // 3: misaligned redirect
        mem_ack = 1'b1; mem_rdata = 32'h0000_0020;
        tick();
        mem_ack = 1'b0; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        inst_ready = 1'b0; redirect_valid = 1'b0;
        check("t3_redirect_addr", 64'(mem_addr), 64'(32'h100));
        check("t3_misalign", 64'(misalign_err), 64'(1));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t3_seq_addr", 64'(mem_addr), 64'(32'h104));
        check("t3_misalign_sticky", 64'(misalign_err), 64'(1));

        // 4: SYSCALL with halt and redirect together
        mem_ack = 1'b1; mem_rdata = 32'h0000_000C;
        tick();
        mem_ack = 1'b0;
        check("t4_opcode", 64'(opcode), 64'(RTYPE));
        check("t4_funct", 64'(funct), 64'(SYSCALL));
        inst_ready = 1'b1; halt_req = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        halt_req = 1'b0; redirect_valid = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_halted", 64'(halted), 64'(1));
            check("t4_req_off", 64'(mem_req), 64'(0));
            check("t4_valid_off", 64'(inst_valid), 64'(0));
            check("t4_pc_kept", 64'(mem_addr), 64'(32'h104));
            tick();
        end
        mem_ack = 1'b0; inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
        check("t4_fetch_count", 64'(fetch_count), 64'(6));
`endif

        // 6: reset while a request is outstanding
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        check("t6_req_up", 64'(mem_req), 64'(1));
        tick();
        #1 rst_b = 1'b0;
        #1 check("t6_req_async_drop", 64'(mem_req), 64'(0));
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tick();
        check("t6_no_capture", 64'(inst), 64'(0));
        check("t6_valid_rst", 64'(inst_valid), 64'(0));
        rst_b = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t6_restart_req", 64'(mem_req), 64'(1));
        check("t6_restart_addr", 64'(mem_addr), 64'(0));
        check("t6_stray_ack", 64'(inst_valid), 64'(0));
        check("t6_halted_clr", 64'(halted), 64'(0));
        check("t6_misalign_clr", 64'(misalign_err), 64'(0));

        // Randomized run against a PC/memory model
        exp_pc = 32'h0; exp_mis = 1'b0; rnd_hs = 0;
        for (int c = 0; c < 400; c++) begin
            if (mem_req) check("rnd_addr", 64'(mem_addr), 64'(exp_pc));
            check("rnd_misalign", 64'(misalign_err), 64'(exp_mis));
            mem_ack        = ($urandom_range(0, 99) < 60);
            mem_rdata      = mem_ack ? mem_word(mem_addr) : $urandom;
            inst_ready     = ($urandom_range(0, 99) < 50);
            redirect_valid = ($urandom_range(0, 3) == 0);
            redirect_pc    = $urandom;
            if (inst_valid && inst_ready) begin
                check("rnd_inst", 64'(inst), 64'(mem_word(exp_pc)));
                check("rnd_inst_pc", 64'(inst_pc), 64'(exp_pc));
                halt_req = 1'b0;
                if (redirect_valid) begin
                    exp_pc = {redirect_pc[31:2], 2'b00};
                    if (redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
                rnd_hs++;
            end else begin
                halt_req = 1'($urandom_range(0, 1));
            end
            tick();
        end
        mem_ack = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
        check("rnd_progress", 64'(rnd_hs >= 20), 64'(1));
        check("rnd_not_halted", 64'(halted), 64'(0));

        // 5: PC wraps from the top of the address space
        b_rst_b = 1'b1;
        @(negedge clk);
        check("t5_req", 64'(b_mem_req), 64'(1));
        check("t5_addr", 64'(b_mem_addr), 64'(32'hFFFF_FFFC));
        b_mem_ack = 1'b1; b_mem_rdata = 32'h0000_0020;
        @(negedge clk);
        b_mem_ack = 1'b0;
        check("t5_inst_pc", 64'(b_inst_pc), 64'(32'hFFFF_FFFC));
        check("t5_valid", 64'(b_inst_valid), 64'(1));
        b_inst_ready = 1'b1;
        @(negedge clk);
        b_inst_ready = 1'b0;
        check("t5_wrap_addr", 64'(b_mem_addr), 64'(32'h0000_0000));
        check("t5_wrap_req", 64'(b_mem_req), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
